// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream, instruction-memory write and status bundle for
//               the boot-time program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  Start;
  logic                  ByteValid;
  logic [7:0]            ByteData;
  logic                  ByteReady;
  logic                  ImemWriteEnable;
  logic [31:0]           ImemWriteAddress;
  logic [31:0]           ImemWriteData;
  logic                  CpuReset;
  logic                  Done;
  logic                  Error;
  logic [ADDR_WIDTH:0]   WordCount;

  // Host/byte-source side.
  modport master (
    output Start, ByteValid, ByteData,
    input  ByteReady, ImemWriteEnable, ImemWriteAddress, ImemWriteData,
           CpuReset, Done, Error, WordCount
  );

  // Loader side.
  modport slave (
    input  Start, ByteValid, ByteData,
    output ByteReady, ImemWriteEnable, ImemWriteAddress, ImemWriteData,
           CpuReset, Done, Error, WordCount
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Framed byte-stream loader writing 32-bit words into
//               instruction memory while holding the CPU in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int START_WORD = 0
) (
  input  wire logic     Clk,
  input  wire logic     Rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [32:0] c_CAPACITY = 33'd1 << ADDR_WIDTH;
  localparam logic [32:0] c_START33  = 33'(START_WORD);
  localparam logic [31:0] c_START32  = 32'(START_WORD);

  state_t              r_state;
  state_t              w_nextState;

  logic [7:0]          r_lenHi;
  logic [15:0]         r_len;
  logic [23:0]         r_wordShift;
  logic [1:0]          r_byteIdx;
  logic [7:0]          r_sum;
  logic [ADDR_WIDTH:0] r_wordCount;
  logic                r_wrEn;
  logic [31:0]         r_wrAddr;
  logic [31:0]         r_wrData;

  logic                w_byteReady;
  logic                w_accept;
  logic                w_sessionStart;
  logic [15:0]         w_len;
  logic                w_lenOk;
  logic                w_wordDone;
  logic                w_lastWord;
  logic [31:0]         w_wordValue;
  logic [31:0]         w_wordIndex;
  logic [31:0]         w_writeAddr;

  assign w_byteReady    = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                          (r_state == S_DATA)   || (r_state == S_CHECK);
  assign w_accept       = bus.ByteValid && w_byteReady;
  assign w_sessionStart = bus.Start && ((r_state == S_IDLE) ||
                          (r_state == S_DONE) || (r_state == S_ERROR));

  // The whole frame must fit between START_WORD and the top of memory.
  assign w_len       = {r_lenHi, bus.ByteData};
  assign w_lenOk     = (w_len != 16'd0) && ((33'(w_len) + c_START33) <= c_CAPACITY);

  assign w_wordDone  = (r_byteIdx == 2'd3);
  assign w_lastWord  = ((33'(r_wordCount) + 33'd1) == 33'(r_len));
  assign w_wordValue = {r_wordShift, bus.ByteData};
  assign w_wordIndex = c_START32 + 32'(r_wordCount);
  assign w_writeAddr = {w_wordIndex[29:0], 2'b00};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.Start) w_nextState = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_accept) w_nextState = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_accept) w_nextState = w_lenOk ? S_DATA : S_ERROR;
      end
      S_DATA: begin
        if (w_accept && w_wordDone && w_lastWord) w_nextState = S_CHECK;
      end
      S_CHECK: begin
        if (w_accept) w_nextState = (bus.ByteData == r_sum) ? S_DONE : S_ERROR;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_lenHi     <= 8'd0;
      r_len       <= 16'd0;
      r_wordShift <= 24'd0;
      r_byteIdx   <= 2'd0;
      r_sum       <= 8'd0;
      r_wordCount <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= 32'd0;
      r_wrData    <= 32'd0;
    end else begin
      r_wrEn <= 1'b0;
      if ((r_state == S_IDLE) || w_sessionStart) begin
        r_wordCount <= '0;
        r_sum       <= 8'd0;
        r_byteIdx   <= 2'd0;
      end
      if (w_accept) begin
        case (r_state)
          S_LEN_HI: r_lenHi <= bus.ByteData;
          S_LEN_LO: r_len   <= w_len;
          S_DATA: begin
            r_wordShift <= w_wordValue[23:0];
            r_sum       <= r_sum + bus.ByteData;
            r_byteIdx   <= r_byteIdx + 2'd1;
            // Address is taken from the pre-increment count: word k lands at START_WORD+k.
            if (w_wordDone) begin
              r_wrEn      <= 1'b1;
              r_wrAddr    <= w_writeAddr;
              r_wrData    <= w_wordValue;
              r_wordCount <= r_wordCount + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ByteReady        = w_byteReady;
  assign bus.ImemWriteEnable  = r_wrEn;
  assign bus.ImemWriteAddress = r_wrAddr;
  assign bus.ImemWriteData    = r_wrData;
  assign bus.CpuReset         = (r_state != S_DONE);
  assign bus.Done             = (r_state == S_DONE);
  assign bus.Error            = (r_state == S_ERROR);
  assign bus.WordCount        = r_wordCount;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int c_AW    = 10;
  localparam int c_START = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(c_AW)) bus();

  imem_loader #(.ADDR_WIDTH(c_AW), .START_WORD(c_START)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [7:0]  frame[$];
  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  int          obsCnt[$];
  int          cpuViol = 0;
  logic [31:0] expAddr[$];
  logic [31:0] expData[$];
  logic        expDone;
  logic        expErr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write-port and CPU-reset observer, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.ImemWriteEnable === 1'b1) begin
      obsAddr.push_back(bus.ImemWriteAddress);
      obsData.push_back(bus.ImemWriteData);
      obsCnt.push_back(int'(bus.WordCount));
    end
    if (bus.ByteReady === 1'b1 && bus.CpuReset !== 1'b1) cpuViol++;
  end

  // Frame-level reference: what a correct loader must write and conclude.
  task automatic model();
    int n;
    int sum;
    logic [31:0] w;
    expAddr.delete();
    expData.delete();
    expDone = 1'b0;
    expErr  = 1'b0;
    n = int'({frame[0], frame[1]});
    if (n == 0 || c_START + n > (1 << c_AW)) begin
      expErr = 1'b1;
      return;
    end
    sum = 0;
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        w   = (w << 8) | 32'(frame[2 + 4*k + b]);
        sum = sum + int'(frame[2 + 4*k + b]);
      end
      expAddr.push_back(32'(4 * (c_START + k)));
      expData.push_back(w);
    end
    if ((sum % 256) == int'(frame[2 + 4*n])) expDone = 1'b1;
    else                                     expErr  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapMax);
    int waitCnt;
    repeat ($urandom_range(gapMax, 0)) @(negedge clk);
    bus.ByteValid = 1'b1;
    bus.ByteData  = b;
    waitCnt = 0;
    while (bus.ByteReady !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.ByteReady !== 1'b1) check("byte_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.ByteValid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic do_frame(input int gapMax, input string tag);
    int base;
    int viol0;
    base  = obsAddr.size();
    viol0 = cpuViol;
    pulse_start();
    check({tag, "_ready_after_start"}, 64'(bus.ByteReady), 64'd1);
    foreach (frame[i]) send_byte(frame[i], gapMax);
    repeat (2) @(negedge clk);
    model();
    check({tag, "_num_writes"}, 64'(obsAddr.size() - base), 64'(expAddr.size()));
    for (int i = 0; i < expAddr.size() && base + i < obsAddr.size(); i++) begin
      check({tag, "_addr"}, 64'(obsAddr[base + i]), 64'(expAddr[i]));
      check({tag, "_data"}, 64'(obsData[base + i]), 64'(expData[i]));
      check({tag, "_cnt_at_write"}, 64'(obsCnt[base + i]), 64'(i + 1));
    end
    check({tag, "_done"},      64'(bus.Done),      64'(expDone));
    check({tag, "_error"},     64'(bus.Error),     64'(expErr));
    check({tag, "_cpu_reset"}, 64'(bus.CpuReset),  64'(!expDone));
    check({tag, "_word_count"},64'(bus.WordCount), 64'(expAddr.size()));
    check({tag, "_ready_idle"},64'(bus.ByteReady), 64'd0);
    check({tag, "_cpu_reset_in_load"}, 64'(cpuViol - viol0), 64'd0);
  endtask

  task automatic set_good(input logic [7:0] ck);
    frame = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, ck};
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] b;
    logic [7:0] sum;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    sum = 8'd0;
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      sum = sum + b;
    end
    if (corrupt) sum = sum + 8'($urandom_range(255, 1));
    frame.push_back(sum);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base;
    bus.Start     = 1'b0;
    bus.ByteValid = 1'b0;
    bus.ByteData  = 8'h00;

    // Reset values.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 64'(bus.ByteReady),        64'd0);
    check("rst_wr_en",      64'(bus.ImemWriteEnable),  64'd0);
    check("rst_wr_addr",    64'(bus.ImemWriteAddress), 64'd0);
    check("rst_wr_data",    64'(bus.ImemWriteData),    64'd0);
    check("rst_cpu_reset",  64'(bus.CpuReset),         64'd1);
    check("rst_done",       64'(bus.Done),             64'd0);
    check("rst_error",      64'(bus.Error),            64'd0);
    check("rst_word_count", 64'(bus.WordCount),        64'd0);
    rst = 1'b0;

    // Bytes offered in IDLE are not taken.
    bus.ByteValid = 1'b1;
    bus.ByteData  = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_ready", 64'(bus.ByteReady), 64'd0);
    end
    bus.ByteValid = 1'b0;
    check("idle_no_write", 64'(obsAddr.size()), 64'd0);

    set_good(8'hA7);
    do_frame(0, "good");
    check("good_word0", 64'(obsData[0]), 64'h2008_0005);
    check("good_word1", 64'(obsData[1]), 64'h0109_5020);

    set_good(8'hA6);
    do_frame(0, "bad_sum");

    frame = {8'h00, 8'h00};
    do_frame(0, "len_zero");
    frame = {8'h04, 8'h01};
    do_frame(0, "len_over");

    build_random(1024, 1'b0);
    do_frame(0, "len_full");
    check("full_last_addr", 64'(obsAddr[obsAddr.size() - 1]), 64'hFFC);

    set_good(8'hA7);
    do_frame(3, "good_gaps");

    // Reset in the middle of the second word.
    base  = obsAddr.size();
    frame = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01};
    pulse_start();
    foreach (frame[i]) send_byte(frame[i], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_num_writes", 64'(obsAddr.size() - base), 64'd1);
    if (obsAddr.size() > base) begin
      check("midrst_addr", 64'(obsAddr[base]), 64'd0);
      check("midrst_data", 64'(obsData[base]), 64'h2008_0005);
    end
    check("midrst_ready",     64'(bus.ByteReady),       64'd0);
    check("midrst_cpu_reset", 64'(bus.CpuReset),        64'd1);
    check("midrst_count",     64'(bus.WordCount),       64'd0);
    check("midrst_done",      64'(bus.Done),            64'd0);
    check("midrst_wr_en",     64'(bus.ImemWriteEnable), 64'd0);
    repeat (2) @(negedge clk);
    check("midrst_no_late_write", 64'(obsAddr.size() - base), 64'd1);

    // Restart straight from DONE.
    set_good(8'hA7);
    do_frame(0, "pre_restart");
    frame = {8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
    do_frame(1, "restart");

    for (int t = 0; t < 20; t++) begin
      build_random(int'($urandom_range(6, 1)), ($urandom_range(3, 0) == 0));
      do_frame(3, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
